// File: rtl/mod_addsub_arbiter.sv
// Round-robin arbiter over NREQ requesters feeding one shared Kyber mod-Q add/sub unit.
// A one-entry result register with valid/ready handshake, a sticky range flag and a saturating op counter.
module mod_addsub_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned Q    = 3329,
  parameter int unsigned IDW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_op,
  input  logic [NREQ*12-1:0] req_a,
  input  logic [NREQ*12-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [11:0]        rsp_data,
  output logic               err_range,
  output logic [15:0]        op_count
);

  localparam logic [12:0]    Q13     = 13'(Q);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [11:0]    rsp_data_q, rsp_data_d;
  logic           err_range_q, err_range_d;
  logic [15:0]    op_count_q, op_count_d;

  logic           found;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] cand;
  int unsigned    idx;
  int unsigned    gnt_i;
  logic           can_accept;
  logic           accept;
  logic [11:0]    a_sel, b_sel;
  logic           op_sel;
  logic [12:0]    sum13, diff13, res13;
  logic           range_bad;

  // First valid requester scanning upward from ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign accept     = found && can_accept;

  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[gnt] = 1'b1;
  end

  // Operands are zeroed when nothing is accepted so the datapath never depends on idle inputs.
  always_comb begin
    gnt_i  = int'(gnt);
    a_sel  = '0;
    b_sel  = '0;
    op_sel = 1'b0;
    if (accept) begin
      a_sel  = req_a[12*gnt_i +: 12];
      b_sel  = req_b[12*gnt_i +: 12];
      op_sel = req_op[gnt];
    end
  end

  always_comb begin
    sum13     = {1'b0, a_sel} + {1'b0, b_sel};
    diff13    = {1'b0, a_sel} - {1'b0, b_sel};
    range_bad = ({1'b0, a_sel} >= Q13) || ({1'b0, b_sel} >= Q13);
    if (!op_sel) res13 = (sum13 >= Q13) ? sum13 - Q13 : sum13;
    else         res13 = (a_sel >= b_sel) ? diff13 : diff13 + Q13;
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    err_range_d = err_range_q;
    op_count_d  = op_count_q;
    if (accept) begin
      ptr_d       = (gnt == LAST_ID) ? '0 : gnt + 1'b1;
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt;
      rsp_data_d  = res13[11:0];
      err_range_d = err_range_q | range_bad;
      if (op_count_q != '1) op_count_d = op_count_q + 16'd1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_range_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      err_range_q <= err_range_d;
      op_count_q  <= op_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign err_range = err_range_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/mod_addsub_arbiter.md
MOD_ADDSUB_ARBITER -- requirements
Module: mod_addsub_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter Q, default 3329, Kyber modulus.
REQ-003 SHALL have parameter IDW, default 2, requester-ID width, equal to clog2(NREQ).
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation valid.
REQ-007 SHALL have port req_ready  output  NREQ  per-requester accept, one-hot or zero.
REQ-008 SHALL have port req_op  input  NREQ  per-requester op: 0 = (a+b) mod Q, 1 = (a-b) mod Q.
REQ-009 SHALL have port req_a  input  NREQ*12  packed operand a; requester i occupies bits [12i+11:12i].
REQ-010 SHALL have port req_b  input  NREQ*12  packed operand b, same packing as req_a.
REQ-011 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port rsp_id  output  IDW  index of the requester that owns the result.
REQ-014 SHALL have port rsp_data  output  12  result, always in 0..Q-1 for in-range operands.
REQ-015 SHALL have port err_range  output  1  sticky flag: an accepted operand was >= Q.
REQ-016 SHALL have port op_count  output  16  number of accepted operations, saturating at 16'hFFFF.

Function
REQ-017 SHALL compute one shared result per cycle: add gives a+b, minus Q if the sum is >= Q; sub gives a-b if a >= b, else a-b+Q. Intermediates SHALL be 13 bits.
REQ-018 SHALL define can_accept = !rsp_valid || rsp_ready.
REQ-019 SHALL assert req_ready[g] combinationally only for the granted index g, and only when can_accept=1 and req_valid[g]=1. All other req_ready bits SHALL be 0.
REQ-020 SHALL select g by round-robin:
- Start from pointer ptr.
- g is the first i in ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ) with req_valid[i]=1.
REQ-021 SHALL update ptr to (g+1) mod NREQ on each accepted transfer; otherwise ptr is held.
REQ-022 SHALL have a latency of 1 cycle: the transfer accepted at edge k drives rsp_valid=1, rsp_data and rsp_id from edge k.
REQ-023 SHALL sustain 1 operation/cycle while rsp_ready=1.
REQ-024 SHALL hold rsp_valid, rsp_data and rsp_id stable while rsp_valid=1 and rsp_ready=0.
REQ-025 SHALL clear rsp_valid at an edge where rsp_ready=1 and no transfer is accepted.
REQ-026 SHALL, when the result is consumed and a new transfer is accepted at the same edge, load the new result with no bubble.
REQ-027 SHALL set err_range at an accepted transfer whose a >= Q or b >= Q. rsp_data is then the formula result truncated to 12 bits, with no further guarantee. err_range clears only on reset.
REQ-028 SHALL increment op_count on each accepted transfer and hold it at 16'hFFFF once reached.
REQ-029 SHALL not depend on req_a, req_b or req_op of non-granted requesters, or on any operand when no transfer occurs.

Reset
REQ-030 SHALL, while rst_n=0, immediately force the following, regardless of clk:
- rsp_valid=0, rsp_data=0, rsp_id=0
- ptr=0, err_range=0, op_count=0
- req_ready=0
REQ-031 SHALL, on reset mid-operation, discard any held result without delivering it. The first grant after reset release SHALL start from requester 0.

Verification
REQ-032 SHALL pass the modular-arithmetic scenario. Requester 0 only, rsp_ready=1:
- sub a=5, b=7 -> rsp_data=3327, rsp_id=0 one cycle later.
- add a=3328, b=1 -> rsp_data=0.
- add a=1664, b=1664 -> rsp_data=3328.
REQ-033 SHALL pass the contention scenario. All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, rsp_id follows one cycle later, op_count=5.
REQ-034 SHALL pass the backpressure scenario. rsp_ready=0 with a result held -> req_ready=0 and outputs stable for 3 cycles. Then rsp_ready=1 with req_valid[2]=1 -> old result consumed and new one loaded at the same edge, rsp_id=2.
REQ-035 SHALL pass the reset-mid-operation scenario. Assert rst_n=0 asynchronously while rsp_valid=1 and ptr=2 -> rsp_valid drops without a clock edge. After release, req_valid=4'b1111 -> first grant is 0.
REQ-036 SHALL pass the range-error scenario. Accepted add with a=3329, b=0 -> err_range=1 and it stays 1 through subsequent valid operations until reset.
REQ-037 SHALL pass the saturation scenario. Preload op_count near its limit by forcing or by 65535 operations, then apply 2 more accepts -> op_count=16'hFFFF.
